// File: rtl/host_uart_cmd_pkg.sv
// host_uart_cmd_pkg
//   Constants shared by the host UART command decoder and response encoder:
//   frame ID bytes, cmd_select codes, fixed body fields, frame lengths and
//   the response encoder state encoding.
package host_uart_cmd_pkg;

    localparam logic [7:0]  ACK_ID        = 8'h01;
    localparam logic [7:0]  YAW_ID        = 8'h03;
    localparam logic [7:0]  ERR_ID        = 8'hFF;

    localparam logic [15:0] CMD_ENC_OFF   = 16'h0001;
    localparam logic [15:0] CMD_ENC_ON    = 16'h0002;
    localparam logic [15:0] CMD_YAW       = 16'h0003;
    localparam logic [15:0] CMD_ERR       = 16'hFFFF;

    localparam logic [47:0] ADDR_SENTINEL = 48'hFFFF_FFFF_FFFF;
    localparam logic [7:0]  CMD_ID_BYTE   = 8'h01;

    localparam int          MAX_BYTES     = 10;
    localparam logic [3:0]  ACK_LEN       = 4'd9;
    localparam logic [3:0]  YAW_LEN       = 4'd9;
    localparam logic [3:0]  ERR_LEN       = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_SEND  = 2'd2,
        ST_CHK   = 2'd3
    } enc_state_t;

    typedef logic [MAX_BYTES-1:0][7:0] frame_t;

endpackage

// File: rtl/uart_frame_serializer.sv
// uart_frame_serializer
//   Holds one response frame body, walks it out over a valid/ready byte
//   handshake and accumulates the XOR checksum, which it presents as the
//   final byte when asked.
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   clear        restart: zero byte index and checksum
//   load         capture frame/len into the buffer
//   frame, len   body bytes (byte 0 first) and body length
//   send_body    present buffer byte at the current index
//   send_chk     present the checksum byte
//   tx_ready     downstream accepts the presented byte
//   tx_data      presented byte
//   tx_valid     tx_data valid
//   body_last    last body byte accepted this cycle
//   chk_accept   checksum byte accepted this cycle
module uart_frame_serializer
    import host_uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  frame_t     frame,
    input  logic [3:0] len,
    input  logic       send_body,
    input  logic       send_chk,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       body_last,
    output logic       chk_accept
);

    localparam logic [3:0] IDX_MAX = 4'(MAX_BYTES - 1);

    frame_t     buf_q;
    logic [3:0] len_q;
    logic [3:0] idx_q;
    logic [7:0] csum_q;
    logic       body_accept;

    assign tx_valid    = send_body | send_chk;
    assign body_accept = send_body & tx_ready;
    assign body_last   = body_accept & ((idx_q + 4'd1) == len_q);
    assign chk_accept  = send_chk & tx_ready;

    always_comb begin
        tx_data = 8'h00;
        if (send_body) begin
            tx_data = buf_q[idx_q];
        end else if (send_chk) begin
            tx_data = csum_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            csum_q <= '0;
        end else if (clear) begin
            idx_q  <= '0;
            csum_q <= '0;
        end else if (load) begin
            buf_q  <= frame;
            len_q  <= len;
        end else if (body_accept) begin
            csum_q <= csum_q ^ buf_q[idx_q];
            // Saturate rather than wrap; the FSM leaves SEND on the last byte anyway.
            if (idx_q < IDX_MAX) begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/host_uart_response_enc.sv
// host_uart_response_enc
//   Builds a host response frame (ID byte, body, XOR checksum) from one
//   cmd_select/payload request and streams it to the UART TX byte by byte.
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   start        request pulse, only honoured in IDLE
//   cmd_select   1/2 encrypt off/on ack, 3 yaw response, FFFF error response
//   payload      [47:0] device address, [63:48] yaw value
//   err_code     error code for the error response
//   tx_data      frame byte to the UART TX
//   tx_valid     tx_data valid
//   tx_ready     UART TX accepts the byte
//   done         idle / frame complete
//   error        last request carried an unsupported cmd_select
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start; request latched on start
// ST_BUILD | one cycle: frame buffer loaded, or unsupported cmd rejected
// ST_SEND  | body bytes presented one per handshake
// ST_CHK   | checksum byte presented; done on acceptance
module host_uart_response_enc
    import host_uart_cmd_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  cmd_select,
    input  logic [255:0] payload,
    input  logic [7:0]   err_code,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         done,
    output logic         error
);

    enc_state_t  state_q, state_d;
    logic [15:0] cmd_q;
    logic [47:0] addr_q;
    logic [15:0] yaw_q;
    logic [7:0]  err_code_q;
    logic        done_q, error_q;

    frame_t      frame;
    logic [3:0]  frame_len;
    logic        cmd_ok;

    logic        take, load, send_body, send_chk, set_done, set_err;
    logic        body_last, chk_accept;

    wire         unused_payload = ^payload[255:64];

    always_comb begin
        frame     = '0;
        frame_len = '0;
        cmd_ok    = 1'b1;
        case (cmd_q)
            CMD_ENC_OFF, CMD_ENC_ON: begin
                frame[0] = ACK_ID;
                for (int i = 0; i < 6; i++) begin
                    frame[i+1] = ADDR_SENTINEL[8*i +: 8];
                end
                frame[7]  = CMD_ID_BYTE;
                frame[8]  = (cmd_q == CMD_ENC_ON) ? 8'h01 : 8'h00;
                frame_len = ACK_LEN;
            end
            CMD_YAW: begin
                frame[0] = YAW_ID;
                for (int i = 0; i < 6; i++) begin
                    frame[i+1] = addr_q[8*i +: 8];
                end
                frame[7]  = yaw_q[7:0];
                frame[8]  = yaw_q[15:8];
                frame_len = YAW_LEN;
            end
            CMD_ERR: begin
                frame[0]  = ERR_ID;
                frame[1]  = err_code_q;
                frame_len = ERR_LEN;
            end
            default: cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        load      = 1'b0;
        send_body = 1'b0;
        send_chk  = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    take    = 1'b1;
                    state_d = ST_BUILD;
                end
            end
            ST_BUILD: begin
                if (cmd_ok) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    set_err  = 1'b1;
                    set_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_SEND: begin
                send_body = 1'b1;
                if (body_last) begin
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                send_chk = 1'b1;
                if (chk_accept) begin
                    set_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            yaw_q      <= '0;
            err_code_q <= '0;
            done_q     <= 1'b1;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                cmd_q      <= cmd_select;
                addr_q     <= payload[47:0];
                yaw_q      <= payload[63:48];
                err_code_q <= err_code;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
            end
            if (set_done) begin
                done_q <= 1'b1;
            end
            if (set_err) begin
                error_q <= 1'b1;
            end
        end
    end

    uart_frame_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .clear      (take),
        .load       (load),
        .frame      (frame),
        .len        (frame_len),
        .send_body  (send_body),
        .send_chk   (send_chk),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .body_last  (body_last),
        .chk_accept (chk_accept)
    );

    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_host_uart_response_enc.sv
module tb_host_uart_response_enc;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  cmd_select;
    logic [255:0] payload;
    logic [7:0]   err_code;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         done;
    logic         error;

    host_uart_response_enc dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cmd_select (cmd_select),
        .payload    (payload),
        .err_code   (err_code),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]       cmd;
        logic [47:0]       addr;
        logic [15:0]       yaw;
        logic [7:0]        ec;
        logic [3:0]        n;
        logic [0:9][7:0]   b;
        logic              err;
    } vec_t;

    vec_t       vecs [5];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    bit         exp_err;
    int         first_v;
    int         done_c;
    bit         stall_bad;
    bit         aborted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame straight from the response format rules.
    task automatic model(input logic [15:0] cmd, input logic [47:0] addr,
                         input logic [15:0] yaw, input logic [7:0] ec);
        logic [7:0] cs;
        exp_q.delete();
        exp_err = 1'b0;
        if (cmd == 16'h0001 || cmd == 16'h0002) begin
            exp_q.push_back(8'h01);
            repeat (6) exp_q.push_back(8'hFF);
            exp_q.push_back(8'h01);
            exp_q.push_back((cmd == 16'h0002) ? 8'h01 : 8'h00);
        end else if (cmd == 16'h0003) begin
            exp_q.push_back(8'h03);
            for (int i = 0; i < 6; i++) exp_q.push_back(addr[8*i +: 8]);
            exp_q.push_back(yaw[7:0]);
            exp_q.push_back(yaw[15:8]);
        end else if (cmd == 16'hFFFF) begin
            exp_q.push_back(8'hFF);
            exp_q.push_back(ec);
        end else begin
            exp_err = 1'b1;
        end
        if (!exp_err) begin
            cs = 8'h00;
            foreach (exp_q[i]) cs = cs ^ exp_q[i];
            exp_q.push_back(cs);
        end
    endtask

    task automatic run_txn(input logic [15:0] cmd, input logic [47:0] addr,
                           input logic [15:0] yaw, input logic [7:0] ec,
                           input bit bp, input int inj_start, input int inj_reset);
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        got_q.delete();
        first_v   = -1;
        done_c    = -1;
        stall_bad = 1'b0;
        aborted   = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) payload[32*k +: 32] = $urandom();
        payload[47:0]  = addr;
        payload[63:48] = yaw;
        cmd_select = cmd;
        err_code   = ec;
        start      = 1'b1;
        tx_ready   = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_falls", done, 1'b0);
        check("error_cleared", error, 1'b0);
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                done_c = c;
                break;
            end
            if (tx_valid && first_v < 0) first_v = c;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_bad = 1'b1;
            if (inj_reset >= 0 && got_q.size() == inj_reset && tx_valid) begin
                reset = 1'b1;
                @(negedge clk);
                check("reset_tx_valid", tx_valid, 1'b0);
                check("reset_done", done, 1'b1);
                reset   = 1'b0;
                aborted = 1'b1;
                return;
            end
            tx_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (c == inj_start) begin
                start      = 1'b1;
                cmd_select = 16'h0003;
                payload    = '0;
                err_code   = 8'h55;
            end else begin
                start = 1'b0;
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            @(negedge clk);
        end
        start = 1'b0;
        check("txn_timeout", (done_c < 0), 1'b0);
    endtask

    task automatic compare_frame(input string name, input bit bp);
        check({name, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
        end
        check({name, "_error"}, error, exp_err);
        check({name, "_done"}, done, 1'b1);
        check({name, "_first_valid"}, first_v, exp_err ? -1 : 2);
        check({name, "_stall_hold"}, stall_bad, 1'b0);
        if (!bp || exp_err) check({name, "_done_cycle"}, done_c, exp_q.size() + 2);
    endtask

    initial begin
        vecs[0] = '{16'h0002, 48'h0, 16'h0, 8'h00, 4'd10,
                    {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'h01}, 1'b0};
        vecs[1] = '{16'h0001, 48'h0, 16'h0, 8'h00, 4'd10,
                    {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00}, 1'b0};
        vecs[2] = '{16'h0003, 48'h112233445566, 16'h1234, 8'h00, 4'd10,
                    {8'h03, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h34, 8'h12, 8'h52}, 1'b0};
        vecs[3] = '{16'hFFFF, 48'h0, 16'h0, 8'h07, 4'd3,
                    {8'hFF, 8'h07, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};
        vecs[4] = '{16'h0005, 48'h0, 16'h0, 8'h00, 4'd0, 80'h0, 1'b1};

        reset = 1'b1; start = 1'b0; cmd_select = '0; payload = '0;
        err_code = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_done", done, 1'b1);
        check("rst_error", error, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_done_held", done, 1'b1);

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].cmd, vecs[v].addr, vecs[v].yaw, vecs[v].ec, 1'b0, -1, -1);
            exp_q.delete();
            for (int i = 0; i < int'(vecs[v].n); i++) exp_q.push_back(vecs[v].b[i]);
            exp_err = vecs[v].err;
            compare_frame($sformatf("vec%0d", v), 1'b0);
        end

        // error must persist while idle until the next start
        repeat (5) @(negedge clk);
        check("error_persists", error, 1'b1);
        check("error_tx_idle", tx_valid, 1'b0);

        // second start during a frame must not disturb it
        run_txn(16'h0002, 48'h0, 16'h0, 8'h00, 1'b0, 4, -1);
        model(16'h0002, 48'h0, 16'h0, 8'h00);
        compare_frame("busy_start", 1'b0);
        repeat (2) @(negedge clk);
        check("busy_start_not_queued", done, 1'b1);

        // reset while byte 4 is on the wire; next frame starts fresh
        run_txn(16'h0003, 48'hA1B2C3D4E5F6, 16'hBEEF, 8'h00, 1'b0, -1, 4);
        check("reset_aborted", aborted, 1'b1);
        check("reset_partial_bytes", got_q.size(), 4);
        repeat (2) @(negedge clk);
        check("reset_stays_idle", tx_valid, 1'b0);
        run_txn(16'h0001, 48'h0, 16'h0, 8'h00, 1'b0, -1, -1);
        model(16'h0001, 48'h0, 16'h0, 8'h00);
        compare_frame("after_reset", 1'b0);

        // randomized requests with random backpressure
        for (int r = 0; r < 24; r++) begin
            logic [15:0] cmd;
            logic [47:0] addr;
            logic [15:0] yaw;
            logic [7:0]  ec;
            case ($urandom_range(0, 4))
                0: cmd = 16'h0001;
                1: cmd = 16'h0002;
                2: cmd = 16'h0003;
                3: cmd = 16'hFFFF;
                default: cmd = 16'($urandom());
            endcase
            addr = {16'($urandom()), 32'($urandom())};
            yaw  = 16'($urandom());
            ec   = 8'($urandom());
            run_txn(cmd, addr, yaw, ec, 1'b1, -1, -1);
            model(cmd, addr, yaw, ec);
            compare_frame($sformatf("rnd%0d", r), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
